// File: rtl/udma_clkdiv_cfg_pkg.sv
// Shared types and helpers for the uDMA clock-divider config arbiter.
// Optional SETTLE state is present only with UDMA_CLKDIV_CFG_SETTLE_EN.
package udma_clkdiv_cfg_pkg;

  localparam int DIV_W_DEF = 8;

`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SET,
    ST_CLR,
    ST_SETTLE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SET,
    ST_CLR
  } state_e;
`endif

  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/udma_clkdiv_rr_arb.sv
// Round-robin winner select: search starts at ptr+1 and wraps.
// Ports: req_i, upd_i (pointer load) -> gnt_o one-hot, idx_o winner.
module udma_clkdiv_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ptr_q <= '0;
    else if (upd_i && |req_i) ptr_q <= idx_o;
  end

endmodule

// File: rtl/udma_clkdiv_cfg_arb.sv
// Shares one clock-generator divider port among N_REQ requesters (4-phase).
// Ports: req_i/req_div_i in, gnt_o/busy_o/cur_div_o/err_o out, clk_div_* to gen.
// Macro UDMA_CLKDIV_CFG_SETTLE_EN adds SETTLE_CYC gated cycles after CLR.
module udma_clkdiv_cfg_arb
  import udma_clkdiv_cfg_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int TIMEOUT    = 255,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*DIV_W-1:0] req_div_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               busy_o,
  output logic [DIV_W-1:0]   cur_div_o,
  output logic               err_o,
  input  logic               err_clr_i,
  output logic [DIV_W-1:0]   clk_div_data_o,
  output logic               clk_div_valid_o,
  input  logic               clk_div_ack_i,
  output logic               clock_enable_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  if (TIMEOUT < 1 || SETTLE_CYC < 1) begin : g_bad_param
    $error("udma_clkdiv_cfg_arb: TIMEOUT and SETTLE_CYC must be >= 1");
  end

  state_e        state_q;
  logic [IW-1:0] win_q;
  logic [TW-1:0] tcnt_q;
  logic          to_q;
  logic          ack_q1;
  logic          ack_q2;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;

`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYC - 1);
  logic [SW-1:0] scnt_q;
`endif

  // Pointer is loaded at selection time; the next arbitration only
  // happens after the grant, so this matches updating on grant.
  udma_clkdiv_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req_i  (req_i),
    .upd_i  (state_q == ST_IDLE),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack_q1 <= 1'b0;
      ack_q2 <= 1'b0;
    end else begin
      ack_q1 <= clk_div_ack_i;
      ack_q2 <= ack_q1;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= ST_IDLE;
      win_q           <= '0;
      tcnt_q          <= '0;
      to_q            <= 1'b0;
      gnt_o           <= '0;
      cur_div_o       <= '0;
      err_o           <= 1'b0;
      clk_div_data_o  <= '0;
      clk_div_valid_o <= 1'b0;
      clock_enable_o  <= 1'b1;
`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
      scnt_q          <= '0;
`endif
    end else begin
      gnt_o <= '0;
      // A timeout set later in this block overrides the clear.
      if (err_clr_i) err_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|arb_gnt) begin
            win_q          <= arb_idx;
            clk_div_data_o <= req_div_i[int'(arb_idx)*DIV_W +: DIV_W];
            state_q        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (clk_div_data_o == cur_div_o) begin
            gnt_o[win_q] <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            clk_div_valid_o <= 1'b1;
            clock_enable_o  <= 1'b0;
            tcnt_q          <= '0;
            to_q            <= 1'b0;
            state_q         <= ST_SET;
          end
        end
        ST_SET: begin
          if (ack_q2) begin
            clk_div_valid_o <= 1'b0;
            tcnt_q          <= '0;
            state_q         <= ST_CLR;
          end else if (tcnt_q == TMAX) begin
            err_o           <= 1'b1;
            to_q            <= 1'b1;
            clk_div_valid_o <= 1'b0;
            tcnt_q          <= '0;
            state_q         <= ST_CLR;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_CLR: begin
          if (!ack_q2) begin
            // An unacknowledged value is not taken as programmed.
            if (!to_q) cur_div_o <= clk_div_data_o;
`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
            scnt_q  <= '0;
            state_q <= ST_SETTLE;
`else
            gnt_o[win_q]   <= 1'b1;
            clock_enable_o <= 1'b1;
            state_q        <= ST_IDLE;
`endif
          end else if (tcnt_q == TMAX) begin
            err_o          <= 1'b1;
            gnt_o[win_q]   <= 1'b1;
            clock_enable_o <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
        ST_SETTLE: begin
          if (scnt_q == SMAX) begin
            gnt_o[win_q]   <= 1'b1;
            clock_enable_o <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_clkdiv_cfg_arb.sv
// Directed self-checking bench for udma_clkdiv_cfg_arb.
// Generator model echoes valid as ack two clocks later.
module tb_udma_clkdiv_cfg_arb;

  localparam int N = 4;
  localparam int W = 8;
`ifdef UDMA_CLKDIV_CFG_SETTLE_EN
  localparam int SX = 4;
`else
  localparam int SX = 0;
`endif

  logic           clk = 1'b0;
  logic           rstn_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] req_div_i;
  logic [N-1:0]   gnt_o;
  logic           busy_o;
  logic [W-1:0]   cur_div_o;
  logic           err_o;
  logic           err_clr_i;
  logic [W-1:0]   clk_div_data_o;
  logic           clk_div_valid_o;
  logic           clk_div_ack_i;
  logic           clock_enable_o;

  logic a1 = 1'b0;
  logic ack_gen = 1'b0;
  logic tie0 = 1'b0;

  int total = 0;
  int bad = 0;
  int lat, vcnt, clow;
  logic [N-1:0] g;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1      <= clk_div_valid_o;
    ack_gen <= a1;
  end
  assign clk_div_ack_i = ack_gen & ~tie0;

  udma_clkdiv_cfg_arb dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .req_i           (req_i),
    .req_div_i       (req_div_i),
    .gnt_o           (gnt_o),
    .busy_o          (busy_o),
    .cur_div_o       (cur_div_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i),
    .clk_div_data_o  (clk_div_data_o),
    .clk_div_valid_o (clk_div_valid_o),
    .clk_div_ack_i   (clk_div_ack_i),
    .clock_enable_o  (clock_enable_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_gnt(input int bound, output int l,
                               output int vc, output int cl,
                               output logic [N-1:0] gv);
    l = 0; vc = 0; cl = 0; gv = '0;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (clk_div_valid_o) vc++;
      if (!clock_enable_o) cl++;
      if (gnt_o != '0) begin
        l = k;
        gv = gnt_o;
        req_i = req_i & ~gnt_o;
        break;
      end
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    req_i = '0;
    req_div_i = '0;
    err_clr_i = 1'b0;
    step();
    step();

    check("rst_gnt", gnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cur", cur_div_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", clk_div_data_o, 0);
    check("rst_valid", clk_div_valid_o, 0);
    check("rst_cen", clock_enable_o, 1);

    rstn_i = 1'b1;
    step();

    // single request, divider 4 on requester 1
    req_div_i[1*W +: W] = 8'd4;
    req_i = 4'b0010;
    run_until_gnt(100, lat, vcnt, clow, g);
    check("single_lat", lat, 12 + SX);
    check("single_gnt", g, 4'b0010);
    check("single_vcnt", vcnt, 5);
    check("single_cenlow", clow, 10 + SX);
    check("single_cur", cur_div_o, 4);
    step();
    check("single_gnt_pulse", gnt_o, 0);
    check("single_idle_cen", clock_enable_o, 1);
    check("single_idle_busy", busy_o, 0);

    // redundant request: same divider on requester 2
    req_div_i[2*W +: W] = 8'd4;
    req_i = 4'b0100;
    run_until_gnt(20, lat, vcnt, clow, g);
    check("redun_lat", lat, 2);
    check("redun_gnt", g, 4'b0100);
    check("redun_vcnt", vcnt, 0);
    check("redun_cenlow", clow, 0);
    check("redun_cur", cur_div_o, 4);
    step();

    // reset while in SET
    req_div_i[3*W +: W] = 8'd9;
    req_i = 4'b1000;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (clk_div_valid_o) begin
        vcnt = 1;
        break;
      end
    end
    check("rmid_reached_set", vcnt, 1);
    rstn_i = 1'b0;
    req_i = '0;
    step();
    check("rmid_valid", clk_div_valid_o, 0);
    check("rmid_cen", clock_enable_o, 1);
    check("rmid_busy", busy_o, 0);
    check("rmid_cur", cur_div_o, 0);
    rstn_i = 1'b1;
    repeat (8) step();

    // round-robin fairness from pointer 0
    req_div_i[0*W +: W] = 8'd1;
    req_div_i[1*W +: W] = 8'd2;
    req_div_i[2*W +: W] = 8'd3;
    req_div_i[3*W +: W] = 8'd4;
    req_i = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      int exp_idx;
      logic [N-1:0] exp_g;
      exp_idx = (n + 1) % 4;
      exp_g = '0;
      exp_g[exp_idx] = 1'b1;
      run_until_gnt(100, lat, vcnt, clow, g);
      check($sformatf("rr%0d_gnt", n), g, exp_g);
      check($sformatf("rr%0d_cur", n), cur_div_o, exp_idx + 1);
      check($sformatf("rr%0d_vcnt", n), vcnt, 5);
      check($sformatf("rr%0d_lat", n), lat, 12 + SX);
    end
    step();
    check("rr_idle", busy_o, 0);

    // SET timeout with ack tied low
    tie0 = 1'b1;
    req_div_i[1*W +: W] = 8'd7;
    req_i = 4'b0010;
    run_until_gnt(600, lat, vcnt, clow, g);
    check("to_lat", lat, 258 + SX);
    check("to_vcnt", vcnt, 255);
    check("to_gnt", g, 4'b0010);
    check("to_err", err_o, 1);
    check("to_cur", cur_div_o, 1);
    step();
    check("to_err_sticky", err_o, 1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("to_err_clr", err_o, 0);
    tie0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
